// File: rtl/calc_seq_ctrl_if.sv
// Bundle between two requesters, the shared add/multiply unit, the display path and calc_seq_ctrl.
// The master side is the environment. The slave side is the controller.
interface calc_seq_ctrl_if;
    logic       req0_valid;
    logic       req1_valid;
    logic [1:0] req0_a;
    logic [1:0] req0_b;
    logic [1:0] req1_a;
    logic [1:0] req1_b;
    logic       req0_sel;
    logic       req1_sel;
    logic       req0_ready;
    logic       req1_ready;
    logic [1:0] alu_a;
    logic [1:0] alu_b;
    logic       alu_sel;
    logic [3:0] alu_result;
    logic [3:0] bcd;
    logic       bcd_valid;
    logic       grant_id;
    logic       done;
    logic       err;

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_sel, req1_sel, alu_result,
        input  req0_ready, req1_ready, alu_a, alu_b, alu_sel,
               bcd, bcd_valid, grant_id, done, err
    );

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_sel, req1_sel, alu_result,
        output req0_ready, req1_ready, alu_a, alu_b, alu_sel,
               bcd, bcd_valid, grant_id, done, err
    );
endinterface

// File: rtl/calc_seq_ctrl.sv
// Round-robin sequencer for two requesters that share one add/multiply unit.
// Each operation's BCD result is held on the display for HOLD_CYCLES cycles.
module calc_seq_ctrl #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input logic            clk,
    input logic            rst,
    calc_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] hold_cnt;
    logic [1:0] a_q;
    logic [1:0] b_q;
    logic       sel_q;
    logic       grant_q;
    logic       last_q;
    logic [3:0] result_q;
    logic       err_q;
    logic       any_valid;
    logic       grant;
    logic       xfer;

    // On a tie, the requester that was not served last wins.
    assign any_valid = bus.req0_valid | bus.req1_valid;
    assign grant     = (bus.req0_valid & bus.req1_valid) ? ~last_q : bus.req1_valid;
    assign xfer      = (state == IDLE) && any_valid && !rst;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: each combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_valid) state_nxt = EXEC;
            EXEC:    state_nxt = HOLD;
            HOLD:    if (hold_cnt == 8'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req0_ready = xfer && !grant;
        bus.req1_ready = xfer && grant;
        bus.bcd_valid  = (state == HOLD);
        bus.done       = (state == HOLD) && (hold_cnt == 8'd0) && !rst;
        bus.bcd        = (state == HOLD) ? result_q : 4'hF;
    end

    assign bus.alu_a    = a_q;
    assign bus.alu_b    = b_q;
    assign bus.alu_sel  = sel_q;
    assign bus.grant_id = grant_q;
    assign bus.err      = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= 2'd0;
            b_q      <= 2'd0;
            sel_q    <= 1'b0;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            result_q <= 4'd0;
            err_q    <= 1'b0;
            hold_cnt <= 8'd0;
        end else begin
            if (xfer) begin
                a_q     <= grant ? bus.req1_a   : bus.req0_a;
                b_q     <= grant ? bus.req1_b   : bus.req0_b;
                sel_q   <= grant ? bus.req1_sel : bus.req0_sel;
                grant_q <= grant;
                last_q  <= grant;
            end
            if (state == EXEC) begin
                hold_cnt <= HOLD_LAST;
                // Values outside 0..9 have no BCD digit, so they show as the blank code.
                if (bus.alu_result > 4'd9) begin
                    result_q <= 4'hF;
                    err_q    <= 1'b1;
                end else begin
                    result_q <= bus.alu_result;
                end
            end else if (state == HOLD && hold_cnt != 8'd0) begin
                hold_cnt <= hold_cnt - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Randomised scoreboard bench for calc_seq_ctrl. A reference model predicts the winner and the display
// value of each operation. A monitor compares every displayed digit, latency, grant_id and the err flag.
module tb_calc_seq_ctrl;
    localparam int H = 4;

    typedef struct {
        int gid;
        int bcd;
        int err;
        int t;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic force_en = 1'b0;
    logic [3:0] force_val = 4'd0;
    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;
    int last_grant = 1;
    int err_exp = 0;
    int prev_xfer = -1;
    exp_t q[$];

    calc_seq_ctrl_if bus();

    calc_seq_ctrl #(.HOLD_CYCLES(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment model of the shared unit, with an override used to force out-of-range results.
    assign bus.alu_result = force_en ? force_val :
        (bus.alu_sel ? ({2'b00, bus.alu_a} * {2'b00, bus.alu_b})
                     : ({2'b00, bus.alu_a} + {2'b00, bus.alu_b}));

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int ref_result(input int a, input int b, input int sel);
        return sel ? a * b : a + b;
    endfunction

    task automatic issue(input int v0, input int v1, input int a0, input int b0, input int s0,
                         input int a1, input int b1, input int s1, input int fen, input int fval);
        int w;
        int val;
        bit got;
        @(posedge clk);
        #2;
        bus.req0_valid = v0[0];
        bus.req1_valid = v1[0];
        bus.req0_a     = 2'(a0);
        bus.req0_b     = 2'(b0);
        bus.req0_sel   = s0[0];
        bus.req1_a     = 2'(a1);
        bus.req1_b     = 2'(b1);
        bus.req1_sel   = s1[0];
        w = (v0 != 0 && v1 != 0) ? 1 - last_grant : (v0 != 0 ? 0 : 1);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.req0_ready || bus.req1_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check("ready_timeout", 0, 1);
            return;
        end
        check("ready0", int'(bus.req0_ready), int'(w == 0));
        check("ready1", int'(bus.req1_ready), int'(w == 1));
        force_en  = fen[0];
        force_val = 4'(fval);
        val = fen != 0 ? fval : (w != 0 ? ref_result(a1, b1, s1) : ref_result(a0, b0, s0));
        if (val > 9) begin
            val = 15;
            err_exp = 1;
        end
        q.push_back('{w, val, err_exp, cyc});
        if (prev_xfer >= 0) check("spacing", cyc - prev_xfer, H + 2);
        prev_xfer  = cyc;
        last_grant = w;
    endtask

    // Monitor: consumes one expectation for each completed operation.
    initial begin
        int seen = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 0;
                continue;
            end
            if (bus.bcd_valid) begin
                check("ready0_busy", int'(bus.req0_ready), 0);
                check("ready1_busy", int'(bus.req1_ready), 0);
                if (q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    if (seen == 0) check("latency", cyc, q[0].t + 2);
                    check("bcd", int'(bus.bcd), q[0].bcd);
                    check("err", int'(bus.err), q[0].err);
                    check("grant_id", int'(bus.grant_id), q[0].gid);
                    seen++;
                    if (bus.done) begin
                        check("hold_len", seen, H);
                        check("done_cycle", cyc, q[0].t + 1 + H);
                        void'(q.pop_front());
                        seen = 0;
                    end else if (seen >= H) begin
                        check("done_missing", 0, 1);
                        void'(q.pop_front());
                        seen = 0;
                    end
                end
            end else begin
                check("bcd_idle", int'(bus.bcd), 15);
                check("done_idle", int'(bus.done), 0);
            end
        end
    end

    initial begin
        int t0;
        int v;
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_a = 2'd3; bus.req0_b = 2'd3; bus.req0_sel = 1'b0;
        bus.req1_a = 2'd3; bus.req1_b = 2'd3; bus.req1_sel = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready0", int'(bus.req0_ready), 0);
        check("rst_ready1", int'(bus.req1_ready), 0);
        check("rst_bcd", int'(bus.bcd), 15);
        check("rst_bcd_valid", int'(bus.bcd_valid), 0);
        check("rst_err", int'(bus.err), 0);
        check("rst_grant_id", int'(bus.grant_id), 0);
        check("rst_alu_a", int'(bus.alu_a), 0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Lone req0: 3 + 2.
        issue(1, 0, 3, 2, 0, 0, 0, 0, 0, 0);
        // Held tie: grants alternate.
        for (int i = 0; i < 4; i++) issue(1, 1, i, 1, 0, 2, i, 1, 0, 0);
        // req1: 3 * 3.
        issue(0, 1, 0, 0, 0, 3, 3, 1, 0, 0);
        // A pending req1 is withdrawn before it can be granted. A lone req0 then follows.
        @(posedge clk); #2;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1;
        @(posedge clk); #2;
        @(posedge clk); #2;
        bus.req1_valid = 1'b0;
        issue(1, 0, 2, 2, 1, 0, 0, 0, 0, 0);
        // The unit result is forced to 12.
        issue(1, 0, 1, 1, 0, 0, 0, 0, 1, 12);
        issue(0, 1, 0, 0, 0, 1, 2, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            v = int'($urandom_range(1, 3));
            issue(v & 1, (v >> 1) & 1,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7) == 0), int'($urandom_range(10, 15)));
        end

        // Reset in the second HOLD cycle aborts the operation.
        issue(1, 0, 1, 2, 0, 0, 0, 0, 0, 0);
        t0 = prev_xfer;
        repeat (3) @(posedge clk);
        #2;
        check("abort_in_hold2", cyc, t0 + 3);
        rst = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        q.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        err_exp = 0;
        last_grant = 1;
        prev_xfer = -1;
        @(negedge clk);
        check("abort_bcd_valid", int'(bus.bcd_valid), 0);
        check("abort_bcd", int'(bus.bcd), 15);
        check("abort_done", int'(bus.done), 0);
        check("abort_err", int'(bus.err), 0);
        issue(1, 1, 2, 3, 0, 1, 1, 0, 0, 0);
        issue(1, 1, 1, 3, 1, 3, 2, 1, 0, 0);

        for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
        check("drain", q.size(), 0);
        check("final_err", int'(bus.err), err_exp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/calc_seq_ctrl.md
CALC_SEQ_CTRL -- requirements
Module: calc_seq_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4, meaning the number of cycles a result is held on the display outputs (legal 1..255).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1 each  requester has an operation pending.
REQ-005 SHALL have ports req0_a, req0_b / req1_a, req1_b  input  2 each  operands.
REQ-006 SHALL have ports req0_sel / req1_sel  input  1 each  0 = add, 1 = multiply.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1 each  request accepted this cycle.
REQ-008 SHALL have ports alu_a, alu_b  output  2 each, and alu_sel  output  1, all driving the shared add/multiply unit.
REQ-009 SHALL have port alu_result  input  4  combinational result of the shared unit.
REQ-010 SHALL have port bcd  output  4  result digit for the BCD-to-7-segment decoder.
REQ-011 SHALL have port bcd_valid  output  1  bcd holds a valid result.
REQ-012 SHALL have port grant_id  output  1  index of the requester owning the current operation.
REQ-013 SHALL have port done  output  1  one-cycle pulse at the end of an operation.
REQ-014 SHALL have port err  output  1  sticky flag: alu_result exceeded 9.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC and HOLD.
REQ-016 SHALL, in IDLE with at least one valid, grant by round-robin: the requester not granted last wins a tie; a lone valid wins outright.
REQ-017 SHALL assert reqN_ready combinationally only in IDLE, and only for the granted requester; a transfer occurs when valid and ready are both high.
REQ-018 SHALL, on transfer, latch a, b, sel and grant_id, update last-grant, and go to EXEC.
REQ-019 SHALL hold at most one operation in flight; both ready outputs are 0 in EXEC and HOLD.
REQ-020 SHALL, in EXEC, drive alu_a/alu_b/alu_sel from the latched operands, register alu_result into the result register, and go to HOLD.
REQ-021 SHALL drive alu_* from the latched values at all times, so they are stable outside EXEC.
REQ-022 SHALL, in HOLD, assert bcd_valid and drive bcd from the result register for exactly HOLD_CYCLES cycles.
REQ-023 SHALL assert done in the last HOLD cycle and return to IDLE on the next edge.
REQ-024 SHALL give a fixed latency: transfer at cycle T, EXEC at T+1, bcd_valid from T+2 through T+1+HOLD_CYCLES, done at T+1+HOLD_CYCLES.
REQ-025 SHALL allow a new transfer in the first IDLE cycle after done, giving back-to-back throughput of one operation per HOLD_CYCLES+2 cycles.
REQ-026 SHALL, when the captured alu_result > 9, store 4'hF, set err, and still complete HOLD normally; err clears only on rst.
REQ-027 SHALL drive bcd = 4'hF whenever bcd_valid = 0.
REQ-028 SHALL ignore any valid deasserted before a transfer; no request is recorded.
REQ-029 SHALL NOT change the latched operands if requester inputs change after acceptance.

Reset
REQ-030 SHALL, with rst high at a clock edge, enter IDLE and set last-grant = 1 (so req0 wins the first tie).
REQ-031 SHALL, on that reset, clear the latched operands, result register, grant_id, err, done and bcd_valid to 0, and set bcd = 4'hF.
REQ-032 SHALL let rst abort an operation in EXEC or HOLD, with no done pulse for the aborted operation.
REQ-033 SHALL hold both ready outputs at 0 during reset.

Verification
REQ-034 SHALL pass: req0 a=3, b=2, sel=0 alone -> req0_ready high in the transfer cycle; bcd=5, bcd_valid for 4 cycles starting 2 cycles later; done in the last of those cycles; grant_id=0.
REQ-035 SHALL pass: req0 and req1 valid together, both held -> grants alternate 0, 1, 0, 1, each operation spaced HOLD_CYCLES+2 = 6 cycles apart.
REQ-036 SHALL pass: req1 a=3, b=3, sel=1 -> bcd=9; err stays 0.
REQ-037 SHALL pass: alu_result forced to 12 -> bcd=4'hF during HOLD, err=1 and sticky until rst.
REQ-038 SHALL pass: rst asserted in the 2nd HOLD cycle -> next cycle IDLE, bcd_valid=0, bcd=4'hF, no done; a following req0 tie is granted to req0.
REQ-039 SHALL pass: operands changed on the cycle after transfer -> displayed result reflects the original operands.
